fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side consumer for the async FIFO. Sits in the rclk domain beside the read-pointer/empty logic
//  and the FIFO memory. Issues rinc pops only when the FIFO is non-empty and buffer space is reserved.
//  Presents popped words on a valid/ready stream (m_*) at full throughput (1 word/rclk).
// PARAMETERS
//  DATA_WIDTH  8   width of rdata / m_data
//  RD_LAT      0   FIFO memory read latency: 0 = rdata valid in the cycle rinc is high
//                  (comb mem[raddr]); 1 = rdata valid one rclk after rinc; other values illegal
//  CNT_W       16  width of the delivered-word counter rd_count
// PORTS
//  rclk      in   1           read-domain clock
//  rrst      in   1           asynchronous, active-low reset
//  rd_en     in   1           drain enable; 0 = issue no new pops
//  rempty    in   1           registered empty flag from the read-pointer logic
//  rdata     in   DATA_WIDTH  FIFO memory read data at current raddr
//  rinc      out  1           pop request to the read-pointer logic (combinational)
//  m_valid   out  1           output word valid
//  m_ready   in   1           downstream accept
//  m_data    out  DATA_WIDTH  output word
//  rd_count  out  CNT_W       words delivered on m_* since reset, wraps modulo 2**CNT_W
//  drained   out  1           rempty & buffer empty & nothing in flight (combinational)
// BEHAVIOUR
//  - localparam BUF_DEPTH = 2 + RD_LAT; occ = buffer occupancy 0..BUF_DEPTH; infl = pop awaiting data (RD_LAT=1 only)
//  - rinc = rd_en & ~rempty & ((occ + infl) < BUF_DEPTH); uses registered state only, no m_ready->rinc path
//  - RD_LAT=0: rdata written into buffer on the rclk edge where rinc=1
//  - RD_LAT=1: infl <= rinc each edge; rdata written on the edge where infl=1
//  - Buffer is in-order circular (head/tail pointers, wrap at BUF_DEPTH); m_valid = (occ != 0), m_data = head entry
//  - Transfer = m_valid & m_ready: head advances, rd_count += 1 (wraps)
//  - Same-edge push + pop: occ unchanged, pointers both advance; push into a full buffer is impossible by credit rule
//  - m_data and m_valid hold stable while m_valid & ~m_ready (no retraction, no data change)
//  - Throughput: m_ready held 1 and FIFO non-empty -> one word per rclk after initial fill latency
//      (first m_valid 1 cycle after first rinc for RD_LAT=0, 2 cycles for RD_LAT=1)
//  - rd_en falling: no new rinc from that cycle; in-flight word still captured; buffer keeps draining
//  - rempty rising: rinc drops the same cycle; no data captured from an empty FIFO
//  - Reset (async assert, any time): occ=0, infl=0, pointers=0, m_valid=0, m_data=0, rd_count=0, rinc=0 while rrst low;
//      buffered/in-flight words discarded; read-pointer logic is reset by the same rrst
//  - drained = rempty & (occ==0) & ~infl; reads 1 out of reset because rempty resets to 1
// STRUCTURE
//  - fifo_pkg: DATA_WIDTH default, RD_LAT legal values (localparam RD_LAT_COMB=0, RD_LAT_REG=1), CNT_W default
//  - Sub-module rd_out_buf (#DEPTH,#W): circular buffer with push/pop, occ, head data; instantiated with BUF_DEPTH
//  - Top holds credit logic, infl flop, rd_count; elaboration-time check RD_LAT in {0,1}
// TESTING
//  1 Reset: rrst low -> m_valid=0, m_data=0, rd_count=0, rinc=0, drained=1; assert rrst mid-burst -> same values next sample
//  2 Stream RD_LAT=0: preload 8 words 0x10..0x17, rd_en=1, m_ready=1 -> m_data 0x10..0x17 on 8 consecutive cycles,
//      rd_count=8, drained=1 afterwards
//  3 Stream RD_LAT=1: same preload -> identical order, first m_valid 2 cycles after first rinc, then 1 word/cycle
//  4 Backpressure: m_ready=0 with 5 words queued -> rinc stops after BUF_DEPTH pops, m_data stays 0x10;
//      release -> 0x10..0x14 in order, no loss or duplicate
//  5 rd_en gating: drop rd_en after 3 pops -> exactly 3 words delivered, rinc=0, remaining 5 stay in FIFO, drained=0
//  6 Empty edge: FIFO with 1 word, m_ready random -> exactly 1 rinc, 1 transfer; rd_count wrap check at CNT_W=4: 17 words -> rd_count=1

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the async FIFO read-side stream consumer.
// Holds parameter defaults and the legal read-latency encodings.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_W_DEF      = 16;

    localparam int RD_LAT_COMB = 0;
    localparam int RD_LAT_REG  = 1;

    function automatic int buf_depth(input int rd_lat);
        return 2 + rd_lat;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_rd_out_buf.sv
// In-order circular skid buffer between FIFO pops and the m_* stream.
// Reports occupancy and presents the head entry combinationally.
module rd_out_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int OW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [OW-1:0] occ,
    output logic [W-1:0]  head_data
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign head_data = mem[head];

    // Storage, pointers and occupancy; push and pop may share an edge
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= nxt(tail);
            end
            if (pop) head <= nxt(head);
            unique case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: credit-gated FIFO pops feeding a valid/ready stream.
// Pops never depend on m_ready; buffer space is reserved before each pop.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LAT     = RD_LAT_COMB,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rd_en,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      rd_count,
    output logic                  drained
);

    localparam int BUF_DEPTH = buf_depth(RD_LAT);
    localparam int OW        = $clog2(BUF_DEPTH + 1);

    logic [OW-1:0] occ;
    logic [OW-1:0] used;
    logic          infl;
    logic          push;
    logic          xfer;

    assign used    = occ + {{(OW-1){1'b0}}, infl};
    assign rinc    = rd_en & ~rempty & (used < OW'(BUF_DEPTH));
    assign m_valid = (occ != '0);
    assign xfer    = m_valid & m_ready;
    assign drained = rempty & (occ == '0) & ~infl;

    if (RD_LAT == RD_LAT_REG) begin : g_reg
        // A pop issued this cycle returns its data on the next edge
        always_ff @(posedge rclk or negedge rrst) begin
            if (!rrst) infl <= 1'b0;
            else       infl <= rinc;
        end
        assign push = infl;
    end else if (RD_LAT == RD_LAT_COMB) begin : g_comb
        assign infl = 1'b0;
        assign push = rinc;
    end else begin : g_bad
        $error("fifo_rd_stream: RD_LAT must be 0 or 1");
    end

    rd_out_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (DATA_WIDTH)
    ) u_buf (
        .rclk      (rclk),
        .rrst      (rrst),
        .push      (push),
        .push_data (rdata),
        .pop       (xfer),
        .occ       (occ),
        .head_data (m_data)
    );

    // Delivered-word counter, wraps naturally
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst)     rd_count <= '0;
        else if (xfer) rd_count <= rd_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read side.
// d0: RD_LAT=0, CNT_W=4; d1: RD_LAT=1, CNT_W=16.
module tb_fifo_rd_stream;

    typedef struct {
        bit   inc;
        bit   valid;
        int   data;
        int   cnt;
        bit   drn;
    } vec_t;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       en0 = 1'b0, en1 = 1'b0;
    logic       rdy0 = 1'b0, rdy1 = 1'b0;
    logic       emp0 = 1'b1, emp1 = 1'b1;
    logic [7:0] rdat0 = '0, rdat1 = '0;
    logic       inc0, inc1, val0, val1, drn0, drn1;
    logic [7:0] dat0, dat1;
    logic [3:0] cnt0;
    logic [15:0] cnt1;

    byte unsigned fq0[$], fq1[$], out0[$], out1[$];
    int pops0 = 0, pops1 = 0, perr = 0;
    int nvec = 0, nbad = 0;

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LAT(0), .CNT_W(4)) d0 (
        .rclk(rclk), .rrst(rrst), .rd_en(en0), .rempty(emp0),
        .rdata(rdat0), .rinc(inc0), .m_valid(val0), .m_ready(rdy0),
        .m_data(dat0), .rd_count(cnt0), .drained(drn0)
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LAT(1), .CNT_W(16)) d1 (
        .rclk(rclk), .rrst(rrst), .rd_en(en1), .rempty(emp1),
        .rdata(rdat1), .rinc(inc1), .m_valid(val1), .m_ready(rdy1),
        .m_data(dat1), .rd_count(cnt1), .drained(drn1)
    );

    always #5 rclk = ~rclk;

    // FIFO read side, combinational memory read
    always @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            fq0.delete();
            pops0 = 0;
            emp0 <= 1'b1;
            rdat0 <= '0;
        end else begin
            if (inc0) begin
                if (fq0.size() == 0) perr++;
                else begin
                    void'(fq0.pop_front());
                    pops0++;
                end
            end
            emp0 <= (fq0.size() == 0);
            rdat0 <= (fq0.size() != 0) ? fq0[0] : 8'h00;
        end
    end

    // FIFO read side, registered memory read
    always @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            fq1.delete();
            pops1 = 0;
            emp1 <= 1'b1;
            rdat1 <= '0;
        end else begin
            if (inc1) begin
                if (fq1.size() == 0) perr++;
                else begin
                    rdat1 <= fq1.pop_front();
                    pops1++;
                end
            end
            emp1 <= (fq1.size() == 0);
        end
    end

    // Record every stream transfer
    always @(posedge rclk) begin
        if (rrst) begin
            if (val0 && rdy0) out0.push_back(dat0);
            if (val1 && rdy1) out1.push_back(dat1);
        end
    end

    function automatic int g_inc(input int s);
        return s ? int'(inc1) : int'(inc0);
    endfunction
    function automatic int g_val(input int s);
        return s ? int'(val1) : int'(val0);
    endfunction
    function automatic int g_dat(input int s);
        return s ? int'(dat1) : int'(dat0);
    endfunction
    function automatic int g_cnt(input int s);
        return s ? int'(cnt1) : int'(cnt0);
    endfunction
    function automatic int g_drn(input int s);
        return s ? int'(drn1) : int'(drn0);
    endfunction
    function automatic int g_pops(input int s);
        return s ? pops1 : pops0;
    endfunction
    function automatic int g_qsz(input int s);
        return s ? fq1.size() : fq0.size();
    endfunction
    function automatic int g_osz(input int s);
        return s ? out1.size() : out0.size();
    endfunction
    function automatic int g_out(input int s, input int i);
        return s ? int'(out1[i]) : int'(out0[i]);
    endfunction

    function automatic vec_t mk(bit i, bit v, int d, int c, bit dr);
        vec_t r;
        r.inc = i; r.valid = v; r.data = d; r.cnt = c; r.drn = dr;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int s, input bit e, input bit r);
        if (s != 0) begin en1 = e; rdy1 = r; end
        else        begin en0 = e; rdy0 = r; end
    endtask

    task automatic do_reset();
        @(negedge rclk);
        en0 = 0; en1 = 0; rdy0 = 0; rdy1 = 0;
        rrst = 0;
        #2;
        out0.delete();
        out1.delete();
        @(negedge rclk);
        rrst = 1;
    endtask

    task automatic preload(input int s, input int n, input int base);
        @(negedge rclk);
        for (int i = 0; i < n; i++) begin
            if (s != 0) fq1.push_back(8'(base + i));
            else        fq0.push_back(8'(base + i));
        end
    endtask

    task automatic reset_vals(input int s, input string tag);
        chk({tag, " m_valid"},  g_val(s), 0);
        chk({tag, " m_data"},   g_dat(s), 0);
        chk({tag, " rd_count"}, g_cnt(s), 0);
        chk({tag, " rinc"},     g_inc(s), 0);
        chk({tag, " drained"},  g_drn(s), 1);
    endtask

    task automatic run_table(input int s, input vec_t tb[$], input string tag);
        for (int k = 0; k < tb.size(); k++) begin
            @(negedge rclk);
            set_in(s, 1'b1, 1'b1);
            #1;
            chk($sformatf("%s r%0d rinc", tag, k), g_inc(s), int'(tb[k].inc));
            chk($sformatf("%s r%0d m_valid", tag, k), g_val(s), int'(tb[k].valid));
            if (tb[k].valid)
                chk($sformatf("%s r%0d m_data", tag, k), g_dat(s), tb[k].data);
            chk($sformatf("%s r%0d rd_count", tag, k), g_cnt(s), tb[k].cnt);
            chk($sformatf("%s r%0d drained", tag, k), g_drn(s), int'(tb[k].drn));
        end
    endtask

    vec_t t0[$];
    vec_t t1[$];

    initial begin
        t0.push_back(mk(1, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            t0.push_back(mk(k <= 7, 1, 'h10 + k - 1, k - 1, 0));
        t0.push_back(mk(0, 0, 0, 8, 1));

        t1.push_back(mk(1, 0, 0, 0, 0));
        t1.push_back(mk(1, 0, 0, 0, 0));
        for (int k = 2; k <= 9; k++)
            t1.push_back(mk(k <= 7, 1, 'h10 + k - 2, k - 2, 0));
        t1.push_back(mk(0, 0, 0, 8, 1));

        // Reset state
        #1 rrst = 0;
        #3;
        reset_vals(0, "rst d0");
        reset_vals(1, "rst d1");
        @(negedge rclk);
        rrst = 1;

        // Full-rate stream, combinational memory
        preload(0, 8, 'h10);
        run_table(0, t0, "lat0");
        chk("lat0 pops", pops0, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("lat0 out%0d", i),
                (i < out0.size()) ? g_out(0, i) : -1, 'h10 + i);

        // Full-rate stream, registered memory
        preload(1, 8, 'h10);
        run_table(1, t1, "lat1");
        for (int i = 0; i < 8; i++)
            chk($sformatf("lat1 out%0d", i),
                (i < out1.size()) ? g_out(1, i) : -1, 'h10 + i);

        // Asynchronous reset in the middle of a burst
        do_reset();
        preload(0, 8, 'h40);
        preload(1, 8, 'h40);
        @(negedge rclk);
        en0 = 1; rdy0 = 1; en1 = 1; rdy1 = 1;
        repeat (3) @(posedge rclk);
        #2 rrst = 0;
        @(negedge rclk);
        #1;
        reset_vals(0, "midrst d0");
        reset_vals(1, "midrst d1");
        @(negedge rclk);
        en0 = 0; en1 = 0; rdy0 = 0; rdy1 = 0;
        rrst = 1;

        // Backpressure: only BUF_DEPTH pops while stalled, then drain in order
        for (int s = 0; s < 2; s++) begin
            do_reset();
            preload(s, 5, 'h10);
            @(negedge rclk);
            set_in(s, 1'b1, 1'b0);
            for (int c = 0; c < 8; c++) begin
                @(negedge rclk);
                #1;
                if (g_val(s) != 0)
                    chk($sformatf("bp%0d hold c%0d", s, c), g_dat(s), 'h10);
            end
            chk($sformatf("bp%0d pops", s), g_pops(s), 2 + s);
            chk($sformatf("bp%0d rinc", s), g_inc(s), 0);
            chk($sformatf("bp%0d m_valid", s), g_val(s), 1);
            set_in(s, 1'b1, 1'b1);
            for (int c = 0; c < 40 && g_osz(s) < 5; c++) @(negedge rclk);
            repeat (4) @(negedge rclk);
            chk($sformatf("bp%0d count", s), g_osz(s), 5);
            for (int i = 0; i < 5; i++)
                chk($sformatf("bp%0d out%0d", s, i),
                    (i < g_osz(s)) ? g_out(s, i) : -1, 'h10 + i);
            chk($sformatf("bp%0d drained", s), g_drn(s), 1);
        end

        // rd_en dropped after three pops
        for (int s = 0; s < 2; s++) begin
            do_reset();
            preload(s, 8, 'h20);
            @(negedge rclk);
            set_in(s, 1'b1, 1'b1);
            for (int c = 0; c < 20; c++) begin
                @(posedge rclk);
                #1;
                if (g_pops(s) >= 3) begin
                    set_in(s, 1'b0, 1'b1);
                    break;
                end
            end
            repeat (10) @(negedge rclk);
            #1;
            chk($sformatf("gate%0d pops", s), g_pops(s), 3);
            chk($sformatf("gate%0d delivered", s), g_osz(s), 3);
            chk($sformatf("gate%0d rinc", s), g_inc(s), 0);
            chk($sformatf("gate%0d left", s), g_qsz(s), 5);
            chk($sformatf("gate%0d drained", s), g_drn(s), 0);
            for (int i = 0; i < 3; i++)
                chk($sformatf("gate%0d out%0d", s, i),
                    (i < g_osz(s)) ? g_out(s, i) : -1, 'h20 + i);
        end

        // Single word with random downstream ready
        for (int s = 0; s < 2; s++) begin
            do_reset();
            preload(s, 1, 'h5a);
            for (int c = 0; c < 20; c++) begin
                @(negedge rclk);
                set_in(s, 1'b1, 1'($urandom_range(0, 1)));
            end
            @(negedge rclk);
            set_in(s, 1'b1, 1'b1);
            repeat (3) @(negedge rclk);
            #1;
            chk($sformatf("one%0d pops", s), g_pops(s), 1);
            chk($sformatf("one%0d xfers", s), g_osz(s), 1);
            chk($sformatf("one%0d data", s),
                (g_osz(s) > 0) ? g_out(s, 0) : -1, 'h5a);
            chk($sformatf("one%0d drained", s), g_drn(s), 1);
        end

        // rd_count wraps at CNT_W=4
        do_reset();
        preload(0, 17, 'h30);
        @(negedge rclk);
        en0 = 1; rdy0 = 1;
        for (int c = 0; c < 60 && !(drn0 && out0.size() == 17); c++)
            @(negedge rclk);
        #1;
        chk("wrap xfers", out0.size(), 17);
        chk("wrap rd_count", int'(cnt0), 1);
        chk("wrap drained", int'(drn0), 1);

        chk("pop from empty", perr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
